ram_access_arbiter: RTL

// Shares one generic_ram instance (separate read/write address buses, 1-cycle registered read)

---
 rtl/ram_access_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ram_access_arbiter.sv
// Shares one registered-read RAM between a high-priority CPU port (A) and a low-priority
// display port (B), with a fill engine that writes a constant over a fixed address range.
module ram_access_arbiter #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    STARVE_LIMIT = 4,
  parameter logic [ADDR_WIDTH-1:0] FILL_BASE    = 16'h0200,
  parameter int                    FILL_COUNT   = 1024,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE   = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_start,
  output logic                  init_busy,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] FILL_LAST = ADDR_WIDTH'(FILL_COUNT - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] fill_ptr;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic [SW-1:0]         starve_cnt;
  logic                  arb_open;
  logic                  starved;

  assign arb_open  = !rst && (state == IDLE);
  assign starved   = (starve_cnt == STARVE_MAX);
  assign a_gnt     = arb_open && a_req && !(b_req && starved);
  assign b_gnt     = arb_open && b_req && (!a_req || starved);
  assign init_busy = (state == FILL);
  assign a_rdata   = ram_dout;
  assign b_rdata   = ram_dout;

  // At most one source drives the RAM buses each cycle; unused addresses rest at zero.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_raddr = '0;
    ram_din   = '0;
    if (!rst) begin
      if (state == FILL) begin
        ram_we    = 1'b1;
        ram_waddr = fill_ptr;
        ram_din   = FILL_VALUE;
      end else if (a_gnt) begin
        if (a_we) begin
          ram_we    = 1'b1;
          ram_waddr = a_addr;
          ram_din   = a_wdata;
        end else begin
          ram_raddr = a_addr;
        end
      end else if (b_gnt) begin
        if (b_we) begin
          ram_we    = 1'b1;
          ram_waddr = b_addr;
          ram_din   = b_wdata;
        end else begin
          ram_raddr = b_addr;
        end
      end
    end
  end

  // The starvation counter only moves while arbitrating, so a fill neither ages nor
  // forgives a waiting display request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fill_ptr   <= '0;
      fill_cnt   <= '0;
      starve_cnt <= '0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
    end else begin
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      case (state)
        IDLE: begin
          if (b_gnt || !b_req)
            starve_cnt <= '0;
          else if (!starved)
            starve_cnt <= starve_cnt + 1'b1;
          if (init_start) begin
            state    <= FILL;
            fill_ptr <= FILL_BASE;
            fill_cnt <= '0;
          end
        end
        FILL: begin
          fill_ptr <= fill_ptr + 1'b1;
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == FILL_LAST)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
